// File: rtl/kmac_kdf_driver.sv
// kmac_kdf_driver: feeds a byte-length job of 64-bit words onto the KMAC keymgr KDF
// request channel under ready backpressure, then captures both digest shares.
// Optional feature: define KMAC_KDF_TIMEOUT_EN to bound the digest wait to MaxWait cycles.
//
// state | meaning
// IDLE  | waiting for start_i; digests and error flags held
// SEND  | accepting input words and presenting them as KDF beats
// WAIT  | last beat accepted; waiting for kdf_done_i
// ERR   | drops any pending beat, raises err_o, returns to IDLE
module kmac_kdf_driver #(
    parameter int DW      = 64,
    parameter int DigestW = 256,
    parameter int LenW    = 16,
    parameter int MaxWait = 1024
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic [LenW-1:0]    len_i,
    input  logic               in_valid_i,
    input  logic [DW-1:0]      in_data_i,
    output logic               in_ready_o,
    output logic               kdf_valid_o,
    output logic [DW-1:0]      kdf_data_o,
    output logic [DW/8-1:0]    kdf_strb_o,
    output logic               kdf_last_o,
    input  logic               kdf_ready_i,
    input  logic               kdf_done_i,
    input  logic [DigestW-1:0] kdf_digest0_i,
    input  logic [DigestW-1:0] kdf_digest1_i,
    input  logic               kdf_error_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o,
    output logic [1:0]         err_code_o,
    output logic [DigestW-1:0] digest0_o,
    output logic [DigestW-1:0] digest1_o
);

    localparam int SW = DW / 8;
    localparam int SB = $clog2(SW);

    if (MaxWait < 1) begin : g_bad_max_wait
        $error("kmac_kdf_driver: MaxWait must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, SEND, WAIT, ERR} state_t;

    state_t              state, state_d;
    logic [LenW-1:0]     rem, rem_d;
    logic                sent_last, sent_last_d;
    logic                kdf_valid_d;
    logic [DW-1:0]       kdf_data_d;
    logic [SW-1:0]       kdf_strb_d;
    logic                kdf_last_d;
    logic                done_d;
    logic                err_d;
    logic [1:0]          err_code_d;
    logic [DigestW-1:0]  digest0_d, digest1_d;
    logic                accept;
    logic                beat_full;
    logic                beat_last;
    logic [SW-1:0]       beat_strb;
    logic [LenW-1:0]     beat_take;
`ifdef KMAC_KDF_TIMEOUT_EN
    localparam int CntW = $clog2(MaxWait + 1);
    logic [CntW-1:0]     wait_cnt, wait_cnt_d;
`endif

    assign busy_o     = (state != IDLE);
    assign in_ready_o = (state == SEND) && !sent_last && (!kdf_valid_o || kdf_ready_i);
    assign accept     = in_valid_i && in_ready_o;

    // Byte accounting for the beat formed from the word being accepted this cycle.
    always_comb begin
        beat_full = (rem >= LenW'(SW));
        beat_last = (rem <= LenW'(SW));
        beat_strb = beat_full ? '1 : ((SW'(1) << rem[SB-1:0]) - SW'(1));
        beat_take = beat_full ? LenW'(SW) : rem;
    end

    // Next-state and next-output logic; every register holds unless a branch changes it.
    always_comb begin
        state_d     = state;
        rem_d       = rem;
        sent_last_d = sent_last;
        kdf_valid_d = kdf_valid_o;
        kdf_data_d  = kdf_data_o;
        kdf_strb_d  = kdf_strb_o;
        kdf_last_d  = kdf_last_o;
        done_d      = 1'b0;
        err_d       = err_o;
        err_code_d  = err_code_o;
        digest0_d   = digest0_o;
        digest1_d   = digest1_o;
`ifdef KMAC_KDF_TIMEOUT_EN
        wait_cnt_d  = wait_cnt;
`endif
        case (state)
            IDLE: begin
                if (start_i) begin
                    if (len_i != '0) begin
                        rem_d       = len_i;
                        sent_last_d = 1'b0;
                        err_d       = 1'b0;
                        err_code_d  = 2'd0;
                        state_d     = SEND;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = 2'd1;
                    end
                end
            end
            SEND: begin
                // A done before the last beat is as fatal as an explicit error.
                if (kdf_error_i || kdf_done_i) begin
                    kdf_valid_d = 1'b0;
                    err_d       = 1'b1;
                    err_code_d  = 2'd2;
                    state_d     = ERR;
                end else if (accept) begin
                    kdf_valid_d = 1'b1;
                    kdf_data_d  = in_data_i;
                    kdf_strb_d  = beat_strb;
                    kdf_last_d  = beat_last;
                    rem_d       = rem - beat_take;
                    if (beat_last) begin
                        sent_last_d = 1'b1;
                    end
                end else if (kdf_valid_o && kdf_ready_i) begin
                    kdf_valid_d = 1'b0;
                    if (kdf_last_o) begin
                        state_d = WAIT;
`ifdef KMAC_KDF_TIMEOUT_EN
                        wait_cnt_d = '0;
`endif
                    end
                end
            end
            WAIT: begin
                if (kdf_error_i) begin
                    err_d      = 1'b1;
                    err_code_d = 2'd2;
                    state_d    = ERR;
                end else if (kdf_done_i) begin
                    digest0_d = kdf_digest0_i;
                    digest1_d = kdf_digest1_i;
                    done_d    = 1'b1;
                    state_d   = IDLE;
                end
`ifdef KMAC_KDF_TIMEOUT_EN
                else if (wait_cnt == CntW'(MaxWait - 1)) begin
                    err_d      = 1'b1;
                    err_code_d = 2'd3;
                    state_d    = ERR;
                end else begin
                    wait_cnt_d = wait_cnt + CntW'(1);
                end
`endif
            end
            ERR: begin
                kdf_valid_d = 1'b0;
                err_d       = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state       <= IDLE;
            rem         <= '0;
            sent_last   <= 1'b0;
            kdf_valid_o <= 1'b0;
            kdf_data_o  <= '0;
            kdf_strb_o  <= '0;
            kdf_last_o  <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            err_code_o  <= 2'd0;
            digest0_o   <= '0;
            digest1_o   <= '0;
`ifdef KMAC_KDF_TIMEOUT_EN
            wait_cnt    <= '0;
`endif
        end else begin
            state       <= state_d;
            rem         <= rem_d;
            sent_last   <= sent_last_d;
            kdf_valid_o <= kdf_valid_d;
            kdf_data_o  <= kdf_data_d;
            kdf_strb_o  <= kdf_strb_d;
            kdf_last_o  <= kdf_last_d;
            done_o      <= done_d;
            err_o       <= err_d;
            err_code_o  <= err_code_d;
            digest0_o   <= digest0_d;
            digest1_o   <= digest1_d;
`ifdef KMAC_KDF_TIMEOUT_EN
            wait_cnt    <= wait_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_kmac_kdf_driver.sv
// Scoreboard bench for kmac_kdf_driver: expected beats and digests are queued when a job
// is issued and popped by an independent monitor whenever the DUT presents them.
module tb_kmac_kdf_driver;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         start_i;
    logic [15:0]  len_i;
    logic         in_valid_i;
    logic [63:0]  in_data_i;
    logic         in_ready_o;
    logic         kdf_valid_o;
    logic [63:0]  kdf_data_o;
    logic [7:0]   kdf_strb_o;
    logic         kdf_last_o;
    logic         kdf_ready_i;
    logic         kdf_done_i;
    logic [255:0] kdf_digest0_i;
    logic [255:0] kdf_digest1_i;
    logic         kdf_error_i;
    logic         busy_o;
    logic         done_o;
    logic         err_o;
    logic [1:0]   err_code_o;
    logic [255:0] digest0_o;
    logic [255:0] digest1_o;

    int checks = 0;
    int failures = 0;
    logic [72:0]  beat_q[$];
    logic [511:0] dig_q[$];
    logic [255:0] exp_d0 = '0;
    logic [255:0] exp_d1 = '0;
    int ready_mode = 0;
    int hs_count = 0;
    int last_gap = 0;

    kmac_kdf_driver #(.DW(64), .DigestW(256), .LenW(16), .MaxWait(8)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .len_i(len_i),
        .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_ready_o(in_ready_o),
        .kdf_valid_o(kdf_valid_o), .kdf_data_o(kdf_data_o), .kdf_strb_o(kdf_strb_o),
        .kdf_last_o(kdf_last_o), .kdf_ready_i(kdf_ready_i), .kdf_done_i(kdf_done_i),
        .kdf_digest0_i(kdf_digest0_i), .kdf_digest1_i(kdf_digest1_i),
        .kdf_error_i(kdf_error_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .err_code_o(err_code_o), .digest0_o(digest0_o), .digest1_o(digest1_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fail(input string name, input int act, input int req);
        checks++;
        failures++;
        $display("FAIL %s actual=%0d required=%0d", name, act, req);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // kdf_ready_i pattern: 0 always high, 1 toggling, 2 random, 3 held low.
    initial begin
        kdf_ready_i = 1'b1;
        forever begin
            tick();
            case (ready_mode)
                0: kdf_ready_i = 1'b1;
                1: kdf_ready_i = ~kdf_ready_i;
                2: kdf_ready_i = 1'($urandom_range(0, 1));
                default: kdf_ready_i = 1'b0;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every KDF handshake and every done_o.
    initial begin
        logic [72:0]  stall_v;
        logic [72:0]  e;
        logic [511:0] d;
        bit stalled;
        bit prev_done;
        int ncyc;
        int last_hs;
        stalled = 0; prev_done = 0; ncyc = 0; last_hs = 0; stall_v = '0;
        forever begin
            @(negedge clk_i);
            ncyc++;
            if (!rst_ni) begin
                stalled = 0;
                prev_done = 0;
            end else begin
                if (stalled && kdf_valid_o)
                    chk("stall_hold", {kdf_data_o, kdf_strb_o, kdf_last_o}, stall_v);
                if (kdf_valid_o && kdf_ready_i) begin
                    hs_count++;
                    last_gap = ncyc - last_hs;
                    last_hs = ncyc;
                    if (beat_q.size() == 0) fail("unexpected_beat", hs_count, 0);
                    else begin
                        e = beat_q.pop_front();
                        chk("beat", {kdf_data_o, kdf_strb_o, kdf_last_o}, e);
                    end
                end
                stalled = kdf_valid_o && !kdf_ready_i;
                stall_v = {kdf_data_o, kdf_strb_o, kdf_last_o};
                if (done_o) begin
                    if (prev_done) fail("done_pulse_width", 2, 1);
                    else if (dig_q.size() == 0) fail("unexpected_done", 1, 0);
                    else begin
                        d = dig_q.pop_front();
                        chk("digest0", digest0_o, d[511:256]);
                        chk("digest1", digest1_o, d[255:0]);
                    end
                end
                prev_done = done_o;
            end
        end
    end

    // Starts a job, feeds its words and returns once the DUT sits in WAIT.
    task automatic send_job(input int len, input int rmode, input bit gaps, input bit hold);
        int nb;
        int nbytes;
        int k;
        int guard;
        logic [63:0] w;
        logic [63:0] words[$];
        logic [7:0]  s;
        nb = (len + 7) / 8;
        for (int i = 0; i < nb; i++) begin
            w = {$urandom, $urandom};
            nbytes = len - 8 * i;
            if (nbytes > 8) nbytes = 8;
            s = 8'((1 << nbytes) - 1);
            words.push_back(w);
            beat_q.push_back({w, s, (i == nb - 1)});
        end
        ready_mode = rmode;
        tick();
        start_i = 1'b1;
        len_i = 16'(len);
        tick();
        start_i = 1'b0;
        len_i = 16'($urandom);
        chk("busy_after_start", busy_o, 1);
        chk("err_clear_on_start", {err_o, err_code_o}, 0);
        k = 0;
        guard = 0;
        while (k < nb && guard < 2000) begin
            in_valid_i = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_data_i = words[k];
            @(negedge clk_i);
            if (in_valid_i && in_ready_o) k++;
            tick();
            guard++;
        end
        if (guard >= 2000) fail("feed_timeout", k, nb);
        in_valid_i = hold;
        in_data_i = {$urandom, $urandom};
        if (hold) chk("ready_after_last", in_ready_o, 0);
        guard = 0;
        while ((beat_q.size() != 0 || kdf_valid_o) && guard < 500) begin
            tick();
            guard++;
        end
        if (guard >= 500) fail("drain_timeout", beat_q.size(), 0);
        chk("busy_in_wait", busy_o, 1);
    endtask

    task automatic finish_job(input logic [255:0] d0, input logic [255:0] d1);
        int guard;
        repeat ($urandom_range(0, 3)) tick();
        dig_q.push_back({d0, d1});
        exp_d0 = d0;
        exp_d1 = d1;
        kdf_digest0_i = d0;
        kdf_digest1_i = d1;
        kdf_done_i = 1'b1;
        tick();
        kdf_done_i = 1'b0;
        in_valid_i = 1'b0;
        guard = 0;
        while (dig_q.size() != 0 && guard < 10) begin
            tick();
            guard++;
        end
        if (guard >= 10) fail("done_timeout", dig_q.size(), 0);
        chk("idle_after_done", busy_o, 0);
    endtask

    function automatic logic [255:0] rnd256();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        int h0;
        int n;
        rst_ni = 1'b0; start_i = 1'b0; len_i = '0; in_valid_i = 1'b0; in_data_i = '0;
        kdf_done_i = 1'b0; kdf_error_i = 1'b0; kdf_digest0_i = '0; kdf_digest1_i = '0;
        repeat (3) tick();
        chk("rst_kdf", {kdf_valid_o, kdf_data_o, kdf_strb_o, kdf_last_o}, 0);
        chk("rst_flags", {busy_o, done_o, err_o, err_code_o, in_ready_o}, 0);
        chk("rst_digests", {digest0_o, digest1_o}, 0);
        rst_ni = 1'b1;
        tick();

        // len=16, ready high: two back-to-back full beats
        h0 = hs_count;
        send_job(16, 0, 0, 0);
        chk("t1_handshakes", hs_count - h0, 2);
        chk("t1_consecutive", last_gap, 1);
        finish_job({32{8'hA5}}, rnd256());

        // len=13: partial final strobe, input blocked after the last word
        send_job(13, 0, 0, 1);
        finish_job(rnd256(), rnd256());

        // len=24 with toggling ready
        h0 = hs_count;
        send_job(24, 1, 0, 0);
        chk("t3_handshakes", hs_count - h0, 3);
        finish_job(rnd256(), rnd256());

        // zero length is rejected, next valid start clears the error
        start_i = 1'b1; len_i = 16'd0;
        tick();
        start_i = 1'b0;
        chk("zero_len_err", {err_o, err_code_o}, {1'b1, 2'd1});
        tick();
        chk("zero_len_idle", busy_o, 0);
        send_job(8, 0, 1, 0);
        finish_job(rnd256(), rnd256());

        // randomized jobs
        for (int j = 0; j < 12; j++) begin
            send_job($urandom_range(1, 40), $urandom_range(0, 2), 1, $urandom_range(0, 1));
            finish_job(rnd256(), rnd256());
        end

        // error with a beat pending under stall
        ready_mode = 3;
        tick();
        tick();
        start_i = 1'b1; len_i = 16'd24;
        tick();
        start_i = 1'b0;
        in_valid_i = 1'b1; in_data_i = {$urandom, $urandom};
        @(negedge clk_i);
        chk("t5_ready_in_send", in_ready_o, 1);
        tick();
        in_valid_i = 1'b0;
        chk("t5_pending", kdf_valid_o, 1);
        kdf_error_i = 1'b1;
        tick();
        kdf_error_i = 1'b0;
        chk("t5_dropped", kdf_valid_o, 0);
        chk("t5_err", {err_o, err_code_o}, {1'b1, 2'd2});
        tick();
        chk("t5_idle", busy_o, 0);
        ready_mode = 0;
        tick();

        // error and done together: error wins, digests held
        send_job(8, 0, 0, 0);
        kdf_digest0_i = rnd256(); kdf_digest1_i = rnd256();
        kdf_error_i = 1'b1; kdf_done_i = 1'b1;
        tick();
        kdf_error_i = 1'b0; kdf_done_i = 1'b0;
        chk("t5b_code", err_code_o, 2);
        chk("t5b_digests_held", {digest0_o, digest1_o}, {exp_d0, exp_d1});
        tick();
        chk("t5b_idle", busy_o, 0);

        // digest wait with no done
        send_job(8, 0, 0, 0);
`ifdef KMAC_KDF_TIMEOUT_EN
        n = 0;
        while (err_code_o != 2'd3 && n < 40) begin
            tick();
            n++;
        end
        chk("timeout_code", err_code_o, 3);
        chk("timeout_cycles", n, 8);
        tick();
        chk("timeout_idle", busy_o, 0);
`else
        n = 0;
        repeat (20) begin
            tick();
            n++;
        end
        chk("no_timeout_busy", {busy_o, err_code_o}, {1'b1, 2'd0});
        rst_ni = 1'b0;
        tick();
        exp_d0 = '0;
        exp_d1 = '0;
        chk("midjob_rst_flags", {busy_o, done_o, err_o, err_code_o, kdf_valid_o}, 0);
        chk("midjob_rst_digests", {digest0_o, digest1_o}, {exp_d0, exp_d1});
        rst_ni = 1'b1;
        tick();
`endif
        repeat (3) tick();
        chk("scoreboard_empty", beat_q.size() + dig_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=expired required=finished");
        $fatal(1, "watchdog");
    end

endmodule
